// File: rtl/erase_status_poll_fsm.sv
// Erase status poller: after a block-erase confirm, waits for the selected
// target's ready/busy line, issues Read Status (70h) and re-reads the status
// byte until RDY is set, then reports pass, fail or timeout with a done pulse.
// The flash bus outputs are only meaningful while busy; the controller muxes
// them with the erase command FSM.
module erase_status_poll_fsm #(
  parameter int                TWB_CYCLES     = 4,
  parameter int                TWHR_CYCLES    = 4,
  parameter int                TREA_CYCLES    = 2,
  parameter int                CNT_W          = 16,
  parameter logic [CNT_W-1:0]  TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       ts,
  input  logic       rb,
  input  logic       rb2,
  input  logic [7:0] dq_in,
  output logic       ce,
  output logic       ce2,
  output logic       cle,
  output logic       ale,
  output logic       we_n,
  output logic       re_n,
  output logic       wp,
  output logic [7:0] dq_out,
  output logic       dq_oe,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic       timeout,
  output logic [7:0] status
);

  // Phase counter width; the short tWB/tWHR/tREA waits all fit in 8 bits.
  localparam int PH_W = 8;
  localparam logic [PH_W-1:0]  TWB_LAST  = PH_W'(TWB_CYCLES - 1);
  localparam logic [PH_W-1:0]  TWHR_LAST = PH_W'(TWHR_CYCLES - 1);
  localparam logic [PH_W-1:0]  TREA_LAST = PH_W'(TREA_CYCLES - 1);
  localparam logic [CNT_W-1:0] TOUT_LAST = TIMEOUT_CYCLES - CNT_W'(1);

  localparam logic [7:0] CMD_READ_STATUS = 8'h70;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_WB,
    S_WAIT_RB,
    S_CMD_SETUP,
    S_CMD_LATCH,
    S_WAIT_WHR,
    S_READ_LOW,
    S_READ_SAMPLE,
    S_EVAL,
    S_TOUT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [PH_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]  tcnt_q, tcnt_d;
  logic [CNT_W-1:0]  tcnt_inc;
  logic              tout_hit;
  logic              tsel_q, tsel_d;
  logic              rb_meta_q, rb_sync_q;
  logic [7:0]        status_q, status_d;
  logic              fail_q, fail_d;
  logic              timeout_q, timeout_d;

  logic              ce_q, ce_d;
  logic              ce2_q, ce2_d;
  logic              cle_q, cle_d;
  logic              we_n_q, we_n_d;
  logic              re_n_q, re_n_d;
  logic              wp_q, wp_d;
  logic [7:0]        dq_out_q, dq_out_d;
  logic              dq_oe_q, dq_oe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // The timeout fires on the cycle the counter steps onto TIMEOUT_CYCLES-1,
  // so the whole budget from WAIT_RB entry to done is TIMEOUT_CYCLES cycles.
  assign tcnt_inc = tcnt_q + CNT_W'(1);
  assign tout_hit = (tcnt_inc == TOUT_LAST);

  // Two-flop synchroniser on the ready/busy line of the latched target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rb_meta_q <= 1'b0;
      rb_sync_q <= 1'b0;
    end else begin
      rb_meta_q <= tsel_q ? rb2 : rb;
      rb_sync_q <= rb_meta_q;
    end
  end

  // State, counters and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tcnt_q    <= '0;
      tsel_q    <= 1'b0;
      status_q  <= 8'h00;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      tsel_q    <= tsel_d;
      status_q  <= status_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic: sequencing, phase timing, timeout and result capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tcnt_d    = tcnt_q;
    tsel_d    = tsel_q;
    status_d  = status_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_WAIT_WB;
          tsel_d    = ts;
          status_d  = 8'h00;
          fail_d    = 1'b0;
          timeout_d = 1'b0;
          cnt_d     = '0;
        end
      end

      S_WAIT_WB: begin
        tcnt_d = '0;
        if (cnt_q == TWB_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT_RB;
        end else begin
          cnt_d = cnt_q + PH_W'(1);
        end
      end

      S_WAIT_RB: begin
        tcnt_d = tcnt_inc;
        if (tout_hit) begin
          state_d = S_TOUT;
        end else if (rb_sync_q) begin
          state_d = S_CMD_SETUP;
        end
      end

      S_CMD_SETUP: begin
        tcnt_d  = tcnt_inc;
        state_d = tout_hit ? S_TOUT : S_CMD_LATCH;
      end

      S_CMD_LATCH: begin
        tcnt_d  = tcnt_inc;
        cnt_d   = '0;
        state_d = tout_hit ? S_TOUT : S_WAIT_WHR;
      end

      S_WAIT_WHR: begin
        tcnt_d = tcnt_inc;
        if (tout_hit) begin
          cnt_d   = '0;
          state_d = S_TOUT;
        end else if (cnt_q == TWHR_LAST) begin
          cnt_d   = '0;
          state_d = S_READ_LOW;
        end else begin
          cnt_d = cnt_q + PH_W'(1);
        end
      end

      S_READ_LOW: begin
        tcnt_d = tcnt_inc;
        if (tout_hit) begin
          cnt_d   = '0;
          state_d = S_TOUT;
        end else if (cnt_q == TREA_LAST) begin
          cnt_d   = '0;
          state_d = S_READ_SAMPLE;
        end else begin
          cnt_d = cnt_q + PH_W'(1);
        end
      end

      S_READ_SAMPLE: begin
        tcnt_d   = tcnt_inc;
        status_d = dq_in;
        state_d  = tout_hit ? S_TOUT : S_EVAL;
      end

      S_EVAL: begin
        tcnt_d = tcnt_inc;
        if (status_q[6]) begin
          state_d   = S_DONE;
          fail_d    = status_q[0];
          timeout_d = 1'b0;
        end else if (tout_hit) begin
          state_d = S_TOUT;
        end else begin
          cnt_d   = '0;
          state_d = S_READ_LOW;
        end
      end

      S_TOUT: begin
        state_d   = S_DONE;
        fail_d    = 1'b1;
        timeout_d = 1'b1;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every bus pin comes straight off a flop.
  always_comb begin
    ce_d     = 1'b0;
    ce2_d    = 1'b0;
    cle_d    = 1'b0;
    we_n_d   = 1'b1;
    re_n_d   = 1'b1;
    wp_d     = 1'b1;
    dq_out_d = 8'h00;
    dq_oe_d  = 1'b0;
    busy_d   = 1'b1;
    done_d   = 1'b0;

    case (state_d)
      S_IDLE: begin
        wp_d   = 1'b0;
        busy_d = 1'b0;
      end
      S_DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: begin
        ce_d  = ~tsel_d;
        ce2_d = tsel_d;
      end
    endcase

    case (state_d)
      S_CMD_SETUP: begin
        cle_d    = 1'b1;
        we_n_d   = 1'b0;
        dq_out_d = CMD_READ_STATUS;
        dq_oe_d  = 1'b1;
      end
      S_CMD_LATCH: begin
        cle_d    = 1'b1;
        dq_out_d = CMD_READ_STATUS;
        dq_oe_d  = 1'b1;
      end
      S_READ_LOW, S_READ_SAMPLE: begin
        re_n_d = 1'b0;
      end
      default: begin
      end
    endcase
  end

  // Output registers; reset releases every strobe immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ce_q     <= 1'b0;
      ce2_q    <= 1'b0;
      cle_q    <= 1'b0;
      we_n_q   <= 1'b1;
      re_n_q   <= 1'b1;
      wp_q     <= 1'b0;
      dq_out_q <= 8'h00;
      dq_oe_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      ce_q     <= ce_d;
      ce2_q    <= ce2_d;
      cle_q    <= cle_d;
      we_n_q   <= we_n_d;
      re_n_q   <= re_n_d;
      wp_q     <= wp_d;
      dq_out_q <= dq_out_d;
      dq_oe_q  <= dq_oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ce      = ce_q;
  assign ce2     = ce2_q;
  assign cle     = cle_q;
  assign ale     = 1'b0;
  assign we_n    = we_n_q;
  assign re_n    = re_n_q;
  assign wp      = wp_q;
  assign dq_out  = dq_out_q;
  assign dq_oe   = dq_oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign fail    = fail_q;
  assign timeout = timeout_q;
  assign status  = status_q;

endmodule

// File: tb/tb_erase_status_poll_fsm.sv
// Testbench for erase_status_poll_fsm: directed vector table, reset corner
// cases and randomized transactions against a cycle-count reference model.
module tb_erase_status_poll_fsm;

  localparam int TWB  = 4;
  localparam int TWHR = 4;
  localparam int TREA = 2;
  localparam int TO   = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       ts;
  logic       rb;
  logic       rb2;
  logic [7:0] dq_in;
  logic       ce, ce2, cle, ale, we_n, re_n, wp, dq_oe, busy, done, fail, timeout;
  logic [7:0] dq_out;
  logic [7:0] status;

  int testsRun;
  int testsFailed;

  erase_status_poll_fsm #(
    .TWB_CYCLES    (TWB),
    .TWHR_CYCLES   (TWHR),
    .TREA_CYCLES   (TREA),
    .CNT_W         (16),
    .TIMEOUT_CYCLES(16'd100)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ts     (ts),
    .rb     (rb),
    .rb2    (rb2),
    .dq_in  (dq_in),
    .ce     (ce),
    .ce2    (ce2),
    .cle    (cle),
    .ale    (ale),
    .we_n   (we_n),
    .re_n   (re_n),
    .wp     (wp),
    .dq_out (dq_out),
    .dq_oe  (dq_oe),
    .busy   (busy),
    .done   (done),
    .fail   (fail),
    .timeout(timeout),
    .status (status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ts;
    int          rbLow;
    int          nStat;
    logic [31:0] stats;
    int          startAgainAt;
    logic        startAtDone;
    int          expDone;
    logic        expFail;
    logic        expTimeout;
    logic [7:0]  expStatus;
    int          expReads;
    int          expWe;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] statAt(input logic [31:0] stats, input int nStat, input int idx);
    int k;
    k = (idx < nStat) ? idx : nStat - 1;
    return stats[8*k +: 8];
  endfunction

  // Reference timeline in cycles counted from the start-sampling edge:
  // rb seen high after a 2-cycle synchroniser, fixed command overhead,
  // a read period of TREA+2 and a hard deadline TO cycles after WAIT_RB entry.
  function automatic void modelTxn(input int rbLow, input int nStat, input logic [31:0] stats,
                                   output int doneAt, output logic f, output logic t,
                                   output logic [7:0] st, output int reads, output int we);
    int kRdy, kT, c, r, e;
    logic [7:0] b;
    kRdy   = (rbLow + 2 > TWB) ? rbLow + 2 : TWB;
    kT     = TWB + TO - 2;
    doneAt = kT + 2;
    f      = 1'b1;
    t      = 1'b1;
    st     = 8'h00;
    reads  = 0;
    we     = 0;
    if (kRdy < kT) begin
      c  = kRdy + 1;
      we = 1;
      for (int i = 0; i < 64; i++) begin
        r = c + 2 + TWHR + i * (TREA + 2);
        e = r + TREA + 1;
        b = statAt(stats, nStat, i);
        if (r > kT) break;
        reads = i + 1;
        if (kT >= r + TREA) st = b;
        if (e > kT) break;
        if (b[6]) begin
          doneAt = e + 1;
          f      = b[0];
          t      = 1'b0;
          break;
        end
        if (e == kT) break;
      end
    end
  endfunction

  task automatic applyStimulus(input vec_t v, input string tag);
    int   doneAt, weCnt, readCnt, ceErr, cmdErr;
    logic prevWe, prevRe;
    logic dFail, dTimeout, dBusy;
    logic [7:0] dStatus;
    doneAt  = -1;
    weCnt   = 0;
    readCnt = 0;
    ceErr   = 0;
    cmdErr  = 0;
    prevWe  = 1'b1;
    prevRe  = 1'b1;
    dFail   = 1'b0;
    dTimeout = 1'b0;
    dBusy   = 1'b0;
    dStatus = 8'h00;

    @(negedge clk);
    ts    = v.ts;
    start = 1'b1;
    dq_in = 8'($urandom);
    if (v.ts) begin
      rb  = 1'b1;
      rb2 = (v.rbLow <= 0);
    end else begin
      rb2 = 1'b1;
      rb  = (v.rbLow <= 0);
    end

    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      start = 1'b0;
      ts    = v.ts;
      if (n == v.startAgainAt) begin
        start = 1'b1;
        ts    = ~v.ts;
      end
      if (busy === 1'b1 && (ce !== ~v.ts || ce2 !== v.ts || wp !== 1'b1)) ceErr++;
      if (ale !== 1'b0) ceErr++;
      if (we_n === 1'b0 && prevWe === 1'b1) weCnt++;
      if (we_n === 1'b0 && (cle !== 1'b1 || dq_out !== 8'h70 || dq_oe !== 1'b1 || re_n !== 1'b1)) cmdErr++;
      if (re_n === 1'b0 && prevRe === 1'b1) begin
        readCnt++;
        dq_in = statAt(v.stats, v.nStat, readCnt - 1);
      end
      prevWe = we_n;
      prevRe = re_n;
      if (done === 1'b1) begin
        doneAt   = n;
        dFail    = fail;
        dTimeout = timeout;
        dStatus  = status;
        dBusy    = busy;
        break;
      end
      if (v.ts) rb2 = (n >= v.rbLow);
      else      rb  = (n >= v.rbLow);
    end

    checkOutput({tag, ".doneCycle"}, doneAt, v.expDone);
    checkOutput({tag, ".fail"}, dFail, v.expFail);
    checkOutput({tag, ".timeout"}, dTimeout, v.expTimeout);
    checkOutput({tag, ".status"}, dStatus, v.expStatus);
    checkOutput({tag, ".busyAtDone"}, dBusy, 0);
    checkOutput({tag, ".reads"}, readCnt, v.expReads);
    checkOutput({tag, ".weStrobes"}, weCnt, v.expWe);
    checkOutput({tag, ".ceWpAle"}, ceErr, 0);
    checkOutput({tag, ".cmdCycle"}, cmdErr, 0);

    if (v.startAtDone) begin
      start = 1'b1;
      ts    = ~v.ts;
    end
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, ".afterDone"}, {done, busy}, 2'b00);
    checkOutput({tag, ".resultHeld"}, {fail, timeout, status}, {v.expFail, v.expTimeout, v.expStatus});
  endtask

  initial begin
    vec_t rv;
    int   mDone, mReads, mWe;
    logic mFail, mTout;
    logic [7:0] mStat, b;
    logic seen;

    testsRun    = 0;
    testsFailed = 0;
    rst   = 1'b0;
    start = 1'b0;
    ts    = 1'b0;
    rb    = 1'b1;
    rb2   = 1'b1;
    dq_in = 8'h00;

    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                {ce, ce2, cle, ale, we_n, re_n, wp, dq_out, dq_oe, busy, done, fail, timeout, status},
                {4'b0000, 2'b11, 1'b0, 8'h00, 5'b00000, 8'h00});
    rst = 1'b1;
    repeat (2) @(negedge clk);

    //            ts    rbLow nSt stats         again atDone done fail  tout  status reads we
    vecs[0]  = '{1'b0,   20, 1, 32'h000000E0, -1, 1'b0,  33, 1'b0, 1'b0, 8'hE0,  1, 1};
    vecs[1]  = '{1'b0,   20, 1, 32'h000000E1, -1, 1'b0,  33, 1'b1, 1'b0, 8'hE1,  1, 1};
    vecs[2]  = '{1'b1,    0, 3, 32'h00C08080, -1, 1'b0,  23, 1'b0, 1'b0, 8'hC0,  3, 1};
    vecs[3]  = '{1'b0, 1000, 1, 32'h000000E0, -1, 1'b0, 104, 1'b1, 1'b1, 8'h00,  0, 0};
    vecs[4]  = '{1'b0,   20, 1, 32'h000000E0, 10, 1'b1,  33, 1'b0, 1'b0, 8'hE0,  1, 1};
    vecs[5]  = '{1'b1,    3, 2, 32'h00004100, -1, 1'b0,  20, 1'b1, 1'b0, 8'h41,  2, 1};
    vecs[6]  = '{1'b1,    0, 1, 32'h00000080, -1, 1'b0, 104, 1'b1, 1'b1, 8'h80, 23, 1};
    vecs[7]  = '{1'b0,   99, 1, 32'h000000E0, -1, 1'b0, 104, 1'b1, 1'b1, 8'h00,  0, 1};
    vecs[8]  = '{1'b1,  100, 1, 32'h000000E0, -1, 1'b0, 104, 1'b1, 1'b1, 8'h00,  0, 0};
    vecs[9]  = '{1'b0,   90, 1, 32'h000000E0, -1, 1'b1, 103, 1'b0, 1'b0, 8'hE0,  1, 1};
    vecs[10] = '{1'b0,   90, 1, 32'h00000080, -1, 1'b0, 104, 1'b1, 1'b1, 8'h80,  1, 1};

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset while a status read strobe is active.
    @(negedge clk);
    ts    = 1'b0;
    start = 1'b1;
    rb    = 1'b1;
    rb2   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (re_n === 1'b0) seen = 1'b1;
    end
    checkOutput("midop.reachedRead", seen, 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("midop.asyncReset", {re_n, ce, ce2, wp, busy, done, cle, we_n}, 8'b10000001);
    repeat (2) @(negedge clk);
    checkOutput("midop.heldInReset", {busy, done, re_n}, 3'b001);
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(vecs[0], "afterReset");

    // Randomized transactions against the reference model.
    for (int i = 0; i < 30; i++) begin
      rv.ts    = 1'($urandom_range(0, 1));
      rv.rbLow = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 40)) : int'($urandom_range(85, 120));
      rv.nStat = int'($urandom_range(1, 4));
      rv.stats = 32'h0;
      for (int j = 0; j < 4; j++) begin
        b    = 8'($urandom);
        b[6] = 1'b0;
        if (j == rv.nStat - 1) b[6] = ($urandom_range(0, 9) < 7);
        rv.stats[8*j +: 8] = b;
      end
      rv.startAgainAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : -1;
      rv.startAtDone  = 1'($urandom_range(0, 1));
      modelTxn(rv.rbLow, rv.nStat, rv.stats, mDone, mFail, mTout, mStat, mReads, mWe);
      rv.expDone    = mDone;
      rv.expFail    = mFail;
      rv.expTimeout = mTout;
      rv.expStatus  = mStat;
      rv.expReads   = mReads;
      rv.expWe      = mWe;
      applyStimulus(rv, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
